// File: rtl/axi4_sram_slave.sv
// -----------------------------------------------------------------------------
// axi4_sram_slave
//
// Purpose:
//   AXI4 slave backed by a DEPTH x 32-bit on-chip memory. One transaction is in
//   flight at a time. A read takes priority over a write when both address
//   channels are valid in the same cycle. INCR and WRAP bursts both step the
//   address by (1 << size) on each beat. FIXED bursts keep the address constant.
//   Writes use wstrb byte lanes. Reads always return the full 32-bit word.
//
// Parameters:
//   BASE_ADDR : byte address of word 0.
//   DEPTH     : number of 32-bit words. Must be a power of two.
//
// Ports:
//   clk, rst                      : clock; asynchronous active-high reset
//   aw* (addr/valid/ready/id/len/size/burst) : write address channel
//   w*  (data/strb/last/valid/ready)         : write data channel
//   b*  (id/resp/valid/ready)                : write response channel
//   ar* (addr/valid/ready/id/len/size/burst) : read address channel
//   r*  (id/data/resp/last/valid/ready)      : read data channel
//
// Configuration:
//   AXI4_SRAM_RANGE_CHECK_EN : when defined, a beat whose address is outside
//     [BASE_ADDR, BASE_ADDR + 4*DEPTH) is treated as out of range.
//     An out-of-range read beat returns rdata = 0 with SLVERR.
//     An out-of-range write beat writes nothing and forces SLVERR for its burst.
//     When the macro is undefined, every address aliases into the memory.
// -----------------------------------------------------------------------------
module axi4_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    // AW channel
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    // W channel
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // B channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    // AR channel
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    // R channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_e;

    // Word index of a byte address. The top bits are dropped, so any address
    // aliases into the memory.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    // Address of the following beat. 32-bit arithmetic wraps naturally.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
    endfunction

`ifdef AXI4_SRAM_RANGE_CHECK_EN
    // Compare in 33 bits so that BASE_ADDR + 4*DEPTH cannot overflow.
    function automatic logic in_range(input logic [31:0] addr);
        return {1'b0, addr - BASE_ADDR} < (33'(DEPTH) << 2);
    endfunction
`endif

    logic [31:0] mem [DEPTH];

    state_e      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [7:0]  len_q,   len_d;
    logic [2:0]  size_q,  size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  id_q,    id_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        err_q,   err_d;
    logic        arready_q, arready_d;
    logic        wready_q,  wready_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;
    logic [3:0]  bid_q,     bid_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic        rlast_q,   rlast_d;
    logic [3:0]  rid_q,     rid_d;

    logic        ar_hs, aw_hs, w_hs;
    logic [31:0] rd_addr;
    logic        rd_ok, wr_ok;
    logic [31:0] beat_rdata;
    logic [1:0]  beat_rresp;
    logic        wbeat_last, wbeat_err, mem_we;

    // awready is arready gated by arvalid. This gives the read priority in the same cycle.
    assign arready = arready_q;
    assign awready = arready_q & ~arvalid;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;

    assign ar_hs = arready_q & arvalid;
    assign aw_hs = awready & awvalid;
    assign w_hs  = wready_q & wvalid;

    // The registered rdata for a beat is taken from the address of the beat that
    // comes next. In IDLE this is araddr, so the first beat is ready one cycle
    // after the AR handshake.
    always_comb begin
        rd_addr = (state_q == IDLE) ? araddr : next_addr(addr_q, size_q, burst_q);
`ifdef AXI4_SRAM_RANGE_CHECK_EN
        rd_ok = in_range(rd_addr);
        wr_ok = in_range(addr_q);
`else
        rd_ok = 1'b1;
        wr_ok = 1'b1;
`endif
        beat_rdata = rd_ok ? mem[word_idx(rd_addr)] : '0;
        beat_rresp = rd_ok ? RESP_OKAY : RESP_SLVERR;
        wbeat_last = (cnt_q == len_q);
        // The beat counter ends the burst. A wlast that disagrees with it is
        // reported as an error but never ends the burst.
        wbeat_err  = (wlast != wbeat_last) | ~wr_ok;
        mem_we     = w_hs & wr_ok;
    end

    // NOTE: the memory array has no reset. Its contents survive rst, and it
    // stays a plain RAM without a per-word reset network.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[word_idx(addr_q)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // NOTE: every *_d gets its default from *_q before the case statement.
    // Without this the combinational block would infer latches.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        arready_d = arready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;

        unique case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    state_d   = RDATA;
                    arready_d = 1'b0;
                    addr_d    = araddr;
                    len_d     = arlen;
                    size_d    = arsize;
                    burst_d   = arburst;
                    id_d      = arid;
                    cnt_d     = '0;
                    rvalid_d  = 1'b1;
                    rdata_d   = beat_rdata;
                    rresp_d   = beat_rresp;
                    rlast_d   = (arlen == 8'd0);
                    rid_d     = arid;
                end else if (aw_hs) begin
                    state_d   = WDATA;
                    arready_d = 1'b0;
                    wready_d  = 1'b1;
                    addr_d    = awaddr;
                    len_d     = awlen;
                    size_d    = awsize;
                    burst_d   = awburst;
                    id_d      = awid;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                end
            end
            RDATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        state_d   = IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        addr_d  = rd_addr;
                        cnt_d   = cnt_q + 8'd1;
                        rdata_d = beat_rdata;
                        rresp_d = beat_rresp;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                    end
                end
            end
            WDATA: begin
                if (w_hs) begin
                    if (wbeat_last) begin
                        state_d  = WRESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q | wbeat_err) ? RESP_SLVERR : RESP_OKAY;
                        bid_d    = id_q;
                    end else begin
                        addr_d = next_addr(addr_q, size_q, burst_q);
                        cnt_d  = cnt_q + 8'd1;
                        err_d  = err_q | wbeat_err;
                    end
                end
            end
            WRESP: begin
                if (bready) begin
                    state_d   = IDLE;
                    bvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            arready_q <= arready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_sram_slave
//
// Self-checking bench for axi4_sram_slave. The DUT uses DEPTH = 64 so that
// aliasing and 256-beat bursts stay short.
//
// Reference model: a word array indexed by ((addr - BASE) >> 2) % DEPTH. Beat
// addresses are computed as base + i * (1 << size), or held for FIXED bursts.
// Writes update the model when the burst is issued. Reads compare every cycle
// of rvalid against the model.
// -----------------------------------------------------------------------------
module tb_axi4_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi4_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] wd  [256];
    logic [3:0]  ws  [256];
    logic        wl  [256];

    logic  read_done       = 1'b0;
    logic  chk_after_read  = 1'b0;
    time   last_ar_time    = 0;
    time   last_aw_time    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off >> 2) % DEPTH;
    endfunction

    function automatic logic in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 4 * DEPTH;
    endfunction

    function automatic logic [31:0] baddr(input logic [31:0] a, input int i,
                                          input logic [2:0] sz, input logic [1:0] bu);
        if (bu == 2'b00) return a;
        return a + 32'(i) * (32'd1 << sz);
    endfunction

    // Fill the write buffers with random data, full strobes and a correct wlast.
    task automatic fill_w(input int len);
        for (int i = 0; i <= len; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
            wl[i] = (i == len);
        end
    endtask

    // Issue one write burst from wd/ws/wl. Update the model and check the B response.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bu, input bit gaps);
        logic        err;
        logic        ok;
        logic [31:0] a;
        int          n;
        int          dly;
        err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = baddr(addr, i, sz, bu);
            if (wl[i] != (i == int'(len))) err = 1'b1;
`ifdef AXI4_SRAM_RANGE_CHECK_EN
            if (!in_rng(a)) begin
                err = 1'b1;
                continue;
            end
`endif
            for (int b = 0; b < 4; b++)
                if (ws[i][b]) mdl[widx(a)][8*b +: 8] = wd[i][8*b +: 8];
        end

        awaddr = addr; awid = id; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        check("aw_handshake", 32'(ok), 32'd1);
        if (!ok) begin awvalid = 1'b0; return; end
        if (chk_after_read) check("aw_waits_for_read", 32'(read_done), 32'd1);
        @(posedge clk); #1;
        last_aw_time = $time;
        awvalid = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                wvalid = 1'b0;
                repeat (1 + $urandom % 2) begin @(posedge clk); #1; end
            end
            wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 50);
            if (!wready) begin
                check("w_ready_timeout", 32'(wready), 32'd1);
                wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;

        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 50);
        check("b_valid", 32'(bvalid), 32'd1);
        check("b_id", 32'(bid), 32'(id));
        check("b_resp", 32'(bresp), err ? 32'd2 : 32'd0);
        dly = $urandom % 3;
        repeat (dly) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("b_hold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("b_drop", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    // Issue one read burst and check every cycle of rvalid against the model.
    // mode: 0 = rready always high, 1 = toggle 1,0,1,0..., 2 = random.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu, input int mode);
        logic [31:0] exp_d [256];
        logic [1:0]  exp_r [256];
        logic [31:0] a;
        logic        ok;
        int          i;
        int          c;
        for (int k = 0; k <= int'(len); k++) begin
            a = baddr(addr, k, sz, bu);
            exp_d[k] = mdl[widx(a)];
            exp_r[k] = 2'b00;
`ifdef AXI4_SRAM_RANGE_CHECK_EN
            if (!in_rng(a)) begin exp_d[k] = 32'h0; exp_r[k] = 2'b10; end
`endif
        end

        araddr = addr; arid = id; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        check("ar_handshake", 32'(ok), 32'd1);
        if (!ok) begin arvalid = 1'b0; return; end
        @(posedge clk); #1;
        last_ar_time = $time;
        arvalid = 1'b0;

        i = 0;
        c = 0;
        while (i <= int'(len) && c < 4 * (int'(len) + 1) + 20) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (c % 2 == 0);
                default: rready = 1'($urandom % 2);
            endcase
            @(negedge clk);
            check("r_valid", 32'(rvalid), 32'd1);
            check("r_data", rdata, exp_d[i]);
            check("r_last", 32'(rlast), 32'(i == int'(len)));
            check("r_id", 32'(rid), 32'(id));
            check("r_resp", 32'(rresp), 32'(exp_r[i]));
            @(posedge clk); #1;
            if (rready) i++;
            c++;
        end
        check("r_all_beats", 32'(i), 32'(int'(len) + 1));
        rready = 1'b0;
        read_done = 1'b1;
        @(negedge clk);
        check("r_end_valid", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic        ok;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bu;
        logic [31:0] off;
        int          j;

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ids_resps", {24'd0, rid, bid}, 32'd0);
        check("rst_resps", {28'd0, rresp, bresp}, 32'd0);
        rst = 1'b0;

        // Prefill every word so that the model has no unknown entries.
        fill_w(63);
        axi_write(4'h1, BASE, 8'd63, 3'd2, 2'b01, 1'b0);

        // Single write, then a single read.
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF; wl[0] = 1'b1;
        axi_write(4'h5, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 1'b0);
        axi_read(4'h6, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 0);

        // Four-beat INCR with rready toggling.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3); end
        axi_write(4'h2, 32'h8000_0100, 8'd3, 3'd2, 2'b01, 1'b1);
        axi_read(4'h7, 32'h8000_0100, 8'd3, 3'd2, 2'b01, 1);

        // AR and AW asserted in the same cycle. The read must complete first.
        fill_w(1);
        read_done = 1'b0;
        chk_after_read = 1'b1;
        fork
            axi_read(4'h3, BASE + 32'h40, 8'd3, 3'd2, 2'b01, 2);
            axi_write(4'h4, BASE + 32'h80, 8'd1, 3'd2, 2'b01, 1'b0);
        join
        chk_after_read = 1'b0;
        check("ar_before_aw", 32'(last_ar_time < last_aw_time), 32'd1);

        // Byte strobes: 0xFFFFFFFF overwritten with zeros on lanes 0 and 2.
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF; wl[0] = 1'b1;
        axi_write(4'h8, BASE + 32'h30, 8'd0, 3'd2, 2'b01, 1'b0);
        wd[0] = 32'h0; ws[0] = 4'b0101; wl[0] = 1'b1;
        axi_write(4'h8, BASE + 32'h30, 8'd0, 3'd2, 2'b01, 1'b0);
        check("strobe_model", mdl[widx(BASE + 32'h30)], 32'hFF00_FF00);
        axi_read(4'h8, BASE + 32'h30, 8'd0, 3'd2, 2'b01, 0);

        // Early wlast on beat 0 of a two-beat burst: both beats are written and bresp is SLVERR.
        fill_w(1);
        wl[0] = 1'b1;
        axi_write(4'hB, BASE + 32'h50, 8'd1, 3'd2, 2'b01, 1'b0);
        axi_read(4'hB, BASE + 32'h50, 8'd1, 3'd2, 2'b01, 0);

        // 256-beat bursts. The write aliases over the memory several times.
        fill_w(255);
        axi_write(4'hC, BASE, 8'd255, 3'd2, 2'b01, 1'b0);
        axi_read(4'hC, BASE, 8'd255, 3'd2, 2'b01, 0);

        // Randomised traffic: sizes, burst types, strobes, aliasing addresses, bad wlast.
        for (int t = 0; t < 40; t++) begin
            len = 8'($urandom % 12);
            sz  = 3'($urandom % 3);
            bu  = 2'($urandom % 3);
            off = 32'($urandom % (8 * DEPTH)) & ~((32'd1 << sz) - 32'd1);
            if ($urandom % 2 == 0) begin
                fill_w(int'(len));
                for (int i = 0; i <= int'(len); i++) ws[i] = 4'($urandom);
                if ($urandom % 6 == 0) begin
                    j = $urandom % (int'(len) + 1);
                    wl[j] = ~wl[j];
                end
                axi_write(4'($urandom), BASE + off, len, sz, bu, 1'b1);
            end else begin
                axi_read(4'($urandom), BASE + off, len, sz, bu, 2);
            end
        end

        // Reset in the middle of an 8-beat read.
        araddr = BASE + 32'h20; arid = 4'h9; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        check("mid_rst_ar", 32'(ok), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rlast", 32'(rlast), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_rid", 32'(rid), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        rready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        axi_read(4'hA, BASE + 32'h20, 8'd3, 3'd2, 2'b01, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
